// File: rtl/rob_multi_wb_pkg.sv
// ============================================================================
// Module : rob_multi_wb_pkg
// Brief  : Shared opcode classes, id width and entry record for rob_multi_wb.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rob_multi_wb_pkg;

    localparam int ROB_ID_W = 4;

    localparam logic [6:0] LUI     = 7'b0110111;
    localparam logic [6:0] AUIPC   = 7'b0010111;
    localparam logic [6:0] JAL     = 7'b1101111;
    localparam logic [6:0] JALR    = 7'b1100111;
    localparam logic [6:0] B_TYPE  = 7'b1100011;
    localparam logic [6:0] LD_TYPE = 7'b0000011;
    localparam logic [6:0] S_TYPE  = 7'b0100011;
    localparam logic [6:0] I_TYPE  = 7'b0010011;
    localparam logic [6:0] R_TYPE  = 7'b0110011;

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic        mispredict;
        logic [6:0]  typ;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] target;
    } rob_entry_t;

    // Channel-index width; never zero so a single channel still has a port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rob_multi_wb_wb_select.sv
// ============================================================================
// Module : rob_wb_select
// Brief  : Resolves NUM_WB writeback channels against one id, lowest index wins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rob_wb_select #(
    parameter int NUM_WB  = 2,
    parameter int DEPTH_W = 4,
    parameter int IDX_W   = 1
) (
    input  logic [DEPTH_W-1:0]        i_id,
    input  logic [NUM_WB-1:0]         i_wb_valid,
    input  logic [NUM_WB*DEPTH_W-1:0] i_wb_rob_id,
    output logic                      o_hit,
    output logic [IDX_W-1:0]          o_idx
);

    // Scan from the top so the lowest matching channel is the last to assign.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int c = NUM_WB - 1; c >= 0; c--) begin
            if (i_wb_valid[c] && (i_wb_rob_id[c*DEPTH_W +: DEPTH_W] == i_id)) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(c);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rob_multi_wb.sv
// ============================================================================
// Module : rob_multi_wb
// Brief  : Reorder buffer with NUM_WB writeback channels, two lookups, flush.
//          Optional same-cycle lookup bypass: define ROB_WB_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rob_multi_wb
    import rob_multi_wb_pkg::*;
#(
    parameter int DEPTH_W = ROB_ID_W,
    parameter int NUM_WB  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      issue_valid,
    input  logic                      issue_done,
    input  logic [6:0]                issue_type,
    input  logic [31:0]               issue_pc,
    input  logic [4:0]                issue_rd,
    input  logic [31:0]               issue_value,
    output logic                      issue_accept,
    output logic [DEPTH_W-1:0]        issue_rob_id,
    output logic                      full,
    output logic                      empty,
    input  logic [NUM_WB-1:0]         wb_valid,
    input  logic [NUM_WB*DEPTH_W-1:0] wb_rob_id,
    input  logic [NUM_WB*32-1:0]      wb_value,
    input  logic [NUM_WB-1:0]         wb_mispredict,
    input  logic [NUM_WB*32-1:0]      wb_target,
    input  logic [DEPTH_W-1:0]        get_id1,
    input  logic [DEPTH_W-1:0]        get_id2,
    output logic                      get_ready1,
    output logic                      get_ready2,
    output logic [31:0]               get_value1,
    output logic [31:0]               get_value2,
    output logic                      commit_valid,
    output logic [DEPTH_W-1:0]        commit_rob_id,
    output logic [4:0]                commit_rd,
    output logic [31:0]               commit_value,
    output logic                      commit_store,
    output logic                      flush,
    output logic [31:0]               flush_pc
);

    localparam int               DEPTH      = 2 ** DEPTH_W;
    localparam int               IDX_W      = idx_w(NUM_WB);
    localparam logic [DEPTH_W:0] C_FULL_CNT = (DEPTH_W + 1)'(DEPTH);

    rob_entry_t         r_entry [DEPTH];
    logic [DEPTH_W-1:0] r_head;
    logic [DEPTH_W-1:0] r_tail;
    logic [DEPTH_W:0]   r_count;
    logic               r_commit_valid;
    logic [DEPTH_W-1:0] r_commit_rob_id;
    logic [4:0]         r_commit_rd;
    logic [31:0]        r_commit_value;
    logic               r_commit_store;
    logic               r_flush;
    logic [31:0]        r_flush_pc;
    logic               r_flush_pend;
    logic [31:0]        r_flush_tgt;

    logic [31:0]        w_ch_value  [NUM_WB];
    logic [31:0]        w_ch_target [NUM_WB];
    logic               w_wb_hit    [DEPTH];
    logic [IDX_W-1:0]   w_wb_idx    [DEPTH];
    logic               w_full;
    logic               w_commit;
    logic [6:0]         w_head_typ;

    for (genvar gc = 0; gc < NUM_WB; gc++) begin : g_chan
        assign w_ch_value[gc]  = wb_value[gc*32 +: 32];
        assign w_ch_target[gc] = wb_target[gc*32 +: 32];
    end

    for (genvar ge = 0; ge < DEPTH; ge++) begin : g_entry
        rob_wb_select #(
            .NUM_WB  (NUM_WB),
            .DEPTH_W (DEPTH_W),
            .IDX_W   (IDX_W)
        ) u_sel (
            .i_id        (DEPTH_W'(ge)),
            .i_wb_valid  (wb_valid),
            .i_wb_rob_id (wb_rob_id),
            .o_hit       (w_wb_hit[ge]),
            .o_idx       (w_wb_idx[ge])
        );
    end

    assign w_full       = (r_count == C_FULL_CNT);
    assign full         = w_full;
    assign empty        = (r_count == '0);
    assign issue_rob_id = r_tail;
    assign issue_accept = rdy & issue_valid & ~w_full & ~r_flush;
    assign w_head_typ   = r_entry[r_head].typ;
    // Nothing younger than a mispredicted branch may retire before the flush.
    assign w_commit     = rdy & ~r_flush_pend & r_entry[r_head].busy & r_entry[r_head].ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_commit_valid  <= 1'b0;
            r_commit_rob_id <= '0;
            r_commit_rd     <= '0;
            r_commit_value  <= '0;
            r_commit_store  <= 1'b0;
            r_flush         <= 1'b0;
            r_flush_pc      <= '0;
            r_flush_pend    <= 1'b0;
            r_flush_tgt     <= '0;
        end else if (!rdy) begin
            r_commit_valid <= 1'b0;
            r_flush        <= 1'b0;
        end else begin
            r_commit_valid <= 1'b0;
            r_flush        <= 1'b0;
            if (r_flush_pend) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_entry[i].busy       <= 1'b0;
                    r_entry[i].ready      <= 1'b0;
                    r_entry[i].mispredict <= 1'b0;
                end
                r_flush      <= 1'b1;
                r_flush_pc   <= r_flush_tgt;
                r_flush_pend <= 1'b0;
                r_head       <= '0;
                r_tail       <= '0;
                r_count      <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_wb_hit[i] && r_entry[i].busy) begin
                        r_entry[i].ready      <= 1'b1;
                        r_entry[i].value      <= w_ch_value[w_wb_idx[i]];
                        r_entry[i].mispredict <= wb_mispredict[w_wb_idx[i]];
                        r_entry[i].target     <= w_ch_target[w_wb_idx[i]];
                    end
                end
                if (w_commit) begin
                    r_commit_valid  <= 1'b1;
                    r_commit_rob_id <= r_head;
                    r_commit_rd     <= ((w_head_typ == B_TYPE) || (w_head_typ == S_TYPE))
                                       ? 5'd0 : r_entry[r_head].rd;
                    r_commit_value  <= r_entry[r_head].value;
                    r_commit_store  <= (w_head_typ == S_TYPE);
                    r_entry[r_head].busy <= 1'b0;
                    r_head          <= r_head + 1'b1;
                    if (r_entry[r_head].mispredict) begin
                        r_flush_pend <= 1'b1;
                        r_flush_tgt  <= r_entry[r_head].target;
                    end
                end
                if (issue_accept) begin
                    r_entry[r_tail] <= '{busy: 1'b1, ready: issue_done, mispredict: 1'b0,
                                         typ: issue_type, pc: issue_pc, rd: issue_rd,
                                         value: issue_value, target: 32'd0};
                    r_tail <= r_tail + 1'b1;
                end
                case ({issue_accept, w_commit})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    logic [DEPTH_W-1:0] w_get_id  [2];
    logic               w_get_rdy [2];
    logic [31:0]        w_get_val [2];

    assign w_get_id[0] = get_id1;
    assign w_get_id[1] = get_id2;

    for (genvar gp = 0; gp < 2; gp++) begin : g_lookup
`ifdef ROB_WB_BYPASS_EN
        logic             w_bp_hit;
        logic [IDX_W-1:0] w_bp_idx;
        logic             w_rdy;
        logic [31:0]      w_val;

        rob_wb_select #(
            .NUM_WB  (NUM_WB),
            .DEPTH_W (DEPTH_W),
            .IDX_W   (IDX_W)
        ) u_bp (
            .i_id        (w_get_id[gp]),
            .i_wb_valid  (wb_valid),
            .i_wb_rob_id (wb_rob_id),
            .o_hit       (w_bp_hit),
            .o_idx       (w_bp_idx)
        );

        // Stored result first, then a same-cycle writeback, then a done-at-issue.
        always_comb begin
            w_rdy = 1'b0;
            w_val = '0;
            if (r_entry[w_get_id[gp]].busy && r_entry[w_get_id[gp]].ready) begin
                w_rdy = 1'b1;
                w_val = r_entry[w_get_id[gp]].value;
            end else if (rdy && r_entry[w_get_id[gp]].busy && w_bp_hit) begin
                w_rdy = 1'b1;
                w_val = w_ch_value[w_bp_idx];
            end else if (issue_accept && issue_done && (w_get_id[gp] == r_tail)) begin
                w_rdy = 1'b1;
                w_val = issue_value;
            end
        end

        assign w_get_rdy[gp] = w_rdy;
        assign w_get_val[gp] = w_val;
`else
        assign w_get_rdy[gp] = r_entry[w_get_id[gp]].busy & r_entry[w_get_id[gp]].ready;
        assign w_get_val[gp] = w_get_rdy[gp] ? r_entry[w_get_id[gp]].value : 32'd0;
`endif
    end

    assign get_ready1    = w_get_rdy[0];
    assign get_ready2    = w_get_rdy[1];
    assign get_value1    = w_get_val[0];
    assign get_value2    = w_get_val[1];
    assign commit_valid  = r_commit_valid;
    assign commit_rob_id = r_commit_rob_id;
    assign commit_rd     = r_commit_rd;
    assign commit_value  = r_commit_value;
    assign commit_store  = r_commit_store;
    assign flush         = r_flush;
    assign flush_pc      = r_flush_pc;

endmodule

`default_nettype wire

// File: tb/tb_rob_multi_wb.sv
// ============================================================================
// Module : tb_rob_multi_wb
// Brief  : Self-checking bench for rob_multi_wb against an in-order queue model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rob_multi_wb;
    import rob_multi_wb_pkg::*;

    localparam int DW  = 4;
    localparam int NWB = 2;
    localparam int DEP = 16;

    logic             clk, rst, rdy;
    logic             issue_valid, issue_done;
    logic [6:0]       issue_type;
    logic [31:0]      issue_pc, issue_value;
    logic [4:0]       issue_rd;
    logic             issue_accept;
    logic [DW-1:0]    issue_rob_id;
    logic             full, empty;
    logic [NWB-1:0]   wb_valid, wb_mispredict;
    logic [NWB*DW-1:0] wb_rob_id;
    logic [NWB*32-1:0] wb_value, wb_target;
    logic [DW-1:0]    get_id1, get_id2;
    logic             get_ready1, get_ready2;
    logic [31:0]      get_value1, get_value2;
    logic             commit_valid, commit_store, flush;
    logic [DW-1:0]    commit_rob_id;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_value, flush_pc;

    rob_multi_wb #(.DEPTH_W(DW), .NUM_WB(NWB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_done(issue_done), .issue_type(issue_type),
        .issue_pc(issue_pc), .issue_rd(issue_rd), .issue_value(issue_value),
        .issue_accept(issue_accept), .issue_rob_id(issue_rob_id),
        .full(full), .empty(empty),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
        .wb_mispredict(wb_mispredict), .wb_target(wb_target),
        .get_id1(get_id1), .get_id2(get_id2),
        .get_ready1(get_ready1), .get_ready2(get_ready2),
        .get_value1(get_value1), .get_value2(get_value2),
        .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_store(commit_store),
        .flush(flush), .flush_pc(flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Model: the in-flight instructions in program order.
    typedef struct {
        int          id;
        bit          rdy;
        logic [31:0] val;
        bit          mp;
        logic [31:0] tgt;
        logic [4:0]  rd;
        logic [6:0]  typ;
    } ment_t;

    ment_t       mq[$];
    int          mhead;
    bit          mpend;
    logic [31:0] mtgt;
    bit          e_cv, e_cst, e_fl;
    int          e_cid;
    logic [4:0]  e_crd;
    logic [31:0] e_cval, e_fpc;

    typedef struct { int cyc; int id; int rd; logic [31:0] val; bit st; } obs_t;
    typedef struct { int cyc; logic [31:0] pc; } fobs_t;
    obs_t  obs[$];
    fobs_t flog[$];

    function automatic int wb_hit(input int id);
        for (int c = 0; c < NWB; c++)
            if (wb_valid[c] && (wb_rob_id[c*DW +: DW] == DW'(id))) return c;
        return -1;
    endfunction

    function automatic int m_tail();
        return (mhead + mq.size()) % DEP;
    endfunction

    task automatic model_step();
        bit    acc, c;
        int    tail;
        ment_t h;
        if (!rst) begin
            mq.delete(); mhead = 0; mpend = 0; mtgt = 0;
            e_cv = 0; e_cid = 0; e_crd = 0; e_cval = 0; e_cst = 0; e_fl = 0; e_fpc = 0;
            return;
        end
        if (!rdy) begin
            e_cv = 0; e_fl = 0;
            return;
        end
        acc  = issue_valid && (mq.size() < DEP) && !e_fl;
        tail = m_tail();
        e_cv = 0; e_fl = 0;
        if (mpend) begin
            e_fl = 1; e_fpc = mtgt; mpend = 0; mq.delete(); mhead = 0;
            return;
        end
        c = (mq.size() > 0) && mq[0].rdy;
        if (c) h = mq[0];
        for (int j = 0; j < mq.size(); j++) begin
            int ch;
            ch = wb_hit(mq[j].id);
            if (ch >= 0) begin
                mq[j].rdy = 1; mq[j].val = wb_value[ch*32 +: 32];
                mq[j].mp = wb_mispredict[ch]; mq[j].tgt = wb_target[ch*32 +: 32];
            end
        end
        if (c) begin
            void'(mq.pop_front());
            mhead  = (mhead + 1) % DEP;
            e_cv   = 1; e_cid = h.id; e_cval = h.val;
            e_crd  = (h.typ == B_TYPE || h.typ == S_TYPE) ? 5'd0 : h.rd;
            e_cst  = (h.typ == S_TYPE);
            if (h.mp) begin mpend = 1; mtgt = h.tgt; end
        end
        if (acc) mq.push_back('{id: tail, rdy: issue_done, val: issue_value, mp: 0,
                                tgt: 0, rd: issue_rd, typ: issue_type});
    endtask

    task automatic m_look(input logic [DW-1:0] id, output logic r, output logic [31:0] v);
        r = 0; v = 0;
        foreach (mq[j]) if (mq[j].id == int'(id) && mq[j].rdy) begin r = 1; v = mq[j].val; end
`ifdef ROB_WB_BYPASS_EN
        if (!r && rdy) begin
            bit busy;
            int ch;
            busy = 0;
            foreach (mq[j]) if (mq[j].id == int'(id)) busy = 1;
            ch = wb_hit(int'(id));
            if (busy && ch >= 0) begin r = 1; v = wb_value[ch*32 +: 32]; end
            else if (issue_valid && issue_done && mq.size() < DEP && !e_fl && int'(id) == m_tail())
                begin r = 1; v = issue_value; end
        end
`endif
    endtask

    // Step the model on the edge, compare just after it.
    always @(posedge clk) begin
        logic        r1, r2;
        logic [31:0] v1, v2;
        model_step();
        #1;
        cyc_n++;
        m_look(get_id1, r1, v1);
        m_look(get_id2, r2, v2);
        chk("commit_valid", 32'(commit_valid), 32'(e_cv));
        chk("commit_rob_id", 32'(commit_rob_id), 32'(e_cid));
        chk("commit_rd", 32'(commit_rd), 32'(e_crd));
        chk("commit_value", commit_value, e_cval);
        chk("commit_store", 32'(commit_store), 32'(e_cst));
        chk("flush", 32'(flush), 32'(e_fl));
        chk("flush_pc", flush_pc, e_fpc);
        chk("full", 32'(full), 32'(mq.size() == DEP));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("issue_rob_id", 32'(issue_rob_id), 32'(m_tail()));
        chk("issue_accept", 32'(issue_accept),
            32'(rdy && issue_valid && mq.size() < DEP && !e_fl));
        chk("get_ready1", 32'(get_ready1), 32'(r1));
        chk("get_value1", get_value1, v1);
        chk("get_ready2", 32'(get_ready2), 32'(r2));
        chk("get_value2", get_value2, v2);
        if (commit_valid === 1'b1)
            obs.push_back('{cyc: cyc_n, id: int'(commit_rob_id), rd: int'(commit_rd),
                            val: commit_value, st: commit_store});
        if (flush === 1'b1) flog.push_back('{cyc: cyc_n, pc: flush_pc});
    end

    logic [31:0] pc_ctr = 32'h0;

    task automatic clr();
        issue_valid = 0; issue_done = 0; issue_type = I_TYPE; issue_pc = 0;
        issue_rd = 0; issue_value = 0;
        wb_valid = 0; wb_rob_id = 0; wb_value = 0; wb_mispredict = 0; wb_target = 0;
    endtask

    task automatic do_issue(input logic done, input logic [6:0] typ,
                            input logic [4:0] rd, input logic [31:0] val);
        issue_valid = 1; issue_done = done; issue_type = typ; issue_rd = rd;
        issue_value = val; issue_pc = pc_ctr; pc_ctr += 4;
        @(negedge clk);
        issue_valid = 0; issue_done = 0;
    endtask

    task automatic set_wb(input int ch, input int id, input logic [31:0] val,
                          input logic mp, input logic [31:0] tgt);
        wb_valid[ch] = 1; wb_rob_id[ch*DW +: DW] = DW'(id); wb_value[ch*32 +: 32] = val;
        wb_mispredict[ch] = mp; wb_target[ch*32 +: 32] = tgt;
    endtask

    task automatic do_reset();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && empty !== 1'b1; k++) @(negedge clk);
        @(negedge clk);
        chk(name, 32'(empty), 32'd1);
    endtask

    initial begin
        clr(); rst = 0; rdy = 1; get_id1 = 0; get_id2 = 1;
        repeat (3) @(negedge clk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_issue_id", 32'(issue_rob_id), 32'd0);
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        rst = 1;

        // Fill to capacity, refuse the 17th, then drain with two channels.
        obs.delete();
        for (int i = 0; i < DEP; i++) do_issue(1'b0, R_TYPE, 5'(i + 1), 32'd0);
        chk("full_after16", 32'(full), 32'd1);
        issue_valid = 1; #1;
        chk("accept_when_full", 32'(issue_accept), 32'd0);
        @(negedge clk); clr();
        chk("tail_hold_full", 32'(issue_rob_id), 32'd0);
        for (int k = 0; k < 8; k++) begin
            set_wb(0, 2*k, 32'(100 + 2*k), 0, 0);
            set_wb(1, 2*k + 1, 32'(101 + 2*k), 0, 0);
            @(negedge clk);
        end
        clr();
        drain("drain_full");
        chk("fill_commit_count", 32'(obs.size()), 32'd16);
        for (int i = 0; i < obs.size(); i++) begin
            chk("fill_commit_id", 32'(obs[i].id), 32'(i));
            chk("fill_commit_val", obs[i].val, 32'(100 + i));
        end

        // Done-at-issue LUI and a store.
        do_issue(1'b1, LUI, 5'd5, 32'h1000);
        @(negedge clk);
        chk("lui_commit_valid", 32'(commit_valid), 32'd1);
        chk("lui_commit_rd", 32'(commit_rd), 32'd5);
        chk("lui_commit_value", commit_value, 32'h1000);
        do_issue(1'b1, S_TYPE, 5'd9, 32'h55);
        @(negedge clk);
        chk("store_commit_store", 32'(commit_store), 32'd1);
        chk("store_commit_rd", 32'(commit_rd), 32'd0);

        // Out-of-order writeback, in-order commit; rdy=0 in between.
        do_reset(); obs.delete(); get_id1 = 0; get_id2 = 1;
        do_issue(1'b0, R_TYPE, 5'd1, 0);
        do_issue(1'b0, R_TYPE, 5'd2, 0);
        rdy = 0; issue_valid = 1; issue_done = 1;
        repeat (2) @(negedge clk);
        clr(); rdy = 1;
        set_wb(1, 1, 32'h22, 0, 0); get_id1 = 1; #1;
`ifdef ROB_WB_BYPASS_EN
        chk("bypass_ready", 32'(get_ready1), 32'd1);
        chk("bypass_value", get_value1, 32'h22);
`else
        chk("nobypass_ready", 32'(get_ready1), 32'd0);
`endif
        @(negedge clk); clr(); get_id1 = 0;
        set_wb(0, 0, 32'h11, 0, 0);
        @(negedge clk); clr();
        drain("drain_order");
        chk("order_count", 32'(obs.size()), 32'd2);
        if (obs.size() == 2) begin
            chk("order_first_id", 32'(obs[0].id), 32'd0);
            chk("order_first_val", obs[0].val, 32'h11);
            chk("order_second_id", 32'(obs[1].id), 32'd1);
            chk("order_second_val", obs[1].val, 32'h22);
            chk("order_consecutive", 32'(obs[1].cyc - obs[0].cyc), 32'd1);
        end

        // Two channels on one id: lower index wins.
        do_reset(); obs.delete(); get_id1 = 2; get_id2 = 0;
        for (int i = 0; i < 3; i++) do_issue(1'b0, R_TYPE, 5'(i + 3), 0);
        set_wb(0, 2, 32'hAA, 0, 0); set_wb(1, 2, 32'hBB, 0, 0);
        @(negedge clk); clr();
        chk("same_id_lookup", get_value1, 32'hAA);
        set_wb(0, 0, 32'h1, 0, 0); set_wb(1, 1, 32'h2, 0, 0);
        @(negedge clk); clr();
        drain("drain_same_id");
        chk("same_id_count", 32'(obs.size()), 32'd3);
        if (obs.size() == 3) chk("same_id_value", obs[2].val, 32'hAA);

        // Mispredicted branch at id 3 with a ready wrong-path entry behind it.
        do_reset(); obs.delete(); flog.delete(); get_id1 = 3; get_id2 = 4;
        for (int i = 0; i < 3; i++) do_issue(1'b1, I_TYPE, 5'(i + 1), 32'(i));
        do_issue(1'b0, B_TYPE, 5'd7, 0);
        do_issue(1'b1, R_TYPE, 5'd8, 32'h99);
        set_wb(0, 3, 32'h0, 1, 32'h200);
        @(negedge clk); clr();
        for (int k = 0; k < 10 && flog.size() == 0; k++) @(negedge clk);
        chk("flush_seen", 32'(flog.size()), 32'd1);
        chk("mp_commit_count", 32'(obs.size()), 32'd4);
        if (flog.size() == 1 && obs.size() == 4) begin
            chk("branch_id", 32'(obs[3].id), 32'd3);
            chk("branch_rd", 32'(obs[3].rd), 32'd0);
            chk("flush_pc_val", flog[0].pc, 32'h200);
            chk("flush_after_commit", 32'(flog[0].cyc - obs[3].cyc), 32'd1);
        end
        chk("post_flush_empty", 32'(empty), 32'd1);
        chk("post_flush_tail", 32'(issue_rob_id), 32'd0);

        // Pointer wrap with continuous issue-and-retire.
        do_reset(); obs.delete(); get_id1 = 0; get_id2 = 5;
        for (int i = 0; i < 20; i++) do_issue(1'b1, I_TYPE, 5'd1, 32'(i + 1000));
        clr();
        drain("drain_wrap");
        chk("wrap_count", 32'(obs.size()), 32'd20);
        foreach (obs[i]) begin
            chk("wrap_id", 32'(obs[i].id), 32'(i % DEP));
            chk("wrap_val", obs[i].val, 32'(i + 1000));
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/rob_multi_wb.md
Name: rob_multi_wb

Overview:
- Parametrised reorder buffer; successor to the single-width RoB between Decoder, RS/LSB and the register file.
- Accepts one in-order issue per cycle and retires at most one entry per cycle from the head, in order.
- Takes NUM_WB generalised writeback channels and answers two operand lookups.
- Full/empty tracking, and branch mispredict flush with PC redirect.

Parameters:
- DEPTH_W, 4, log2 of entry count (DEPTH = 2**DEPTH_W; 16 entries by default).
- NUM_WB, 2, number of writeback channels (RS, LSB, ...); must be ≥ 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- rdy  in  1  global enable; when 0, all state holds.
- issue_valid  in  1  decoder presents an instruction.
- issue_done  in  1  result already known at issue (LUI/AUIPC/JAL).
- issue_type  in  7  opcode class (shared codes).
- issue_pc  in  32  instruction address.
- issue_rd  in  5  destination register.
- issue_value  in  32  value when issue_done=1.
- issue_accept  out  1  combinational: issue_valid & !full & !flush.
- issue_rob_id  out  DEPTH_W  current tail; the id the next accepted issue gets.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- wb_valid  in  NUM_WB  per-channel result valid.
- wb_rob_id  in  NUM_WB*DEPTH_W  flattened target ids.
- wb_value  in  NUM_WB*32  flattened results.
- wb_mispredict  in  NUM_WB  branch resolved against its prediction.
- wb_target  in  NUM_WB*32  correct next PC for a mispredicted branch.
- get_id1 / get_id2  in  DEPTH_W  lookup ids.
- get_ready1 / get_ready2  out  1  the entry holds a result.
- get_value1 / get_value2  out  32  the result, or 0 when not ready.
- commit_valid  out  1  registered retire pulse.
- commit_rob_id  out  DEPTH_W  retired id.
- commit_rd  out  5  retired rd; 0 for B_TYPE/S_TYPE.
- commit_value  out  32  retired value.
- commit_store  out  1  retired entry is S_TYPE; tells the LSB to perform the store.
- flush  out  1  registered one-cycle clear pulse.
- flush_pc  out  32  redirect target.

Behaviour:
- Reset: head = tail = count = 0; all busy/ready/mispredict bits cleared; every output register is 0.
- Everything below applies only when rdy=1.
- Issue: when issue_accept, write entry[tail] with busy=1 and ready=issue_done; set tail+1 (mod DEPTH).
- Writeback: for each channel with wb_valid and a busy target, set ready=1 and store value, mispredict and target.
  - Writeback to a non-busy id is ignored.
  - Two channels on the same id: the lower index wins.
- Commit: if busy[head] & ready[head], then at the edge:
  - commit_* are loaded from the entry and commit_valid=1;
  - the entry's busy bit is cleared and head is incremented.
  - Otherwise commit_valid=0.
- Commit latency: a writeback at edge k can commit at the earliest at edge k+1.
- Count update:
  - issue-only: +1;
  - commit-only: −1;
  - both in the same cycle: unchanged;
  - full is taken from registered count, so at full an issue is refused even if a commit happens that cycle.
- Mispredict: when the committing entry has mispredict=1:
  - commit still happens that cycle;
  - at the next edge flush=1 and flush_pc = stored target, every busy bit is cleared, and head = tail = count = 0.
  - issue_accept is 0 while flush=1.
- Wrap-around: head and tail are DEPTH_W-bit pointers and wrap naturally; full/empty come from count, never from pointer comparison.
- rdy=0: no issue, writeback or commit; commit_valid and flush are forced to 0.
- rst asserted mid-flush or mid-commit: reset wins.
- Lookup: get_ready = busy & ready for the stored entry; combinational read.

Optional Feature:
- Macro: ROB_WB_BYPASS_EN.
- Defined: a lookup also hits a same-cycle matching wb_valid channel (lower index first) or a same-cycle accepted issue with issue_done at tail. get_ready/get_value reflect that result combinationally.
- Undefined: lookups see only stored state, so a result is visible one cycle after its writeback.

Decomposition:
- Shared package holds:
  - the opcode-class constants (LUI, AUIPC, JAL, JALR, B_TYPE, LD_TYPE, S_TYPE, I_TYPE, R_TYPE);
  - ROB id width;
  - the entry record type {busy, ready, mispredict, type, pc, rd, value, target}.
- One sub-module: rob_wb_select. It is combinational, and resolves NUM_WB channels against one id with the lower-index priority. It is instantiated per entry for writeback and per lookup port for bypass.

Test Plan:
- Issue 16 entries with issue_done=0 → full=1 after the 16th accept; a 17th issue_valid gives issue_accept=0 and tail stays 0.
- Issue LUI with rd=5, value=0x1000, issue_done=1 → the next cycle after the accept edge shows commit_valid=1, commit_rd=5, commit_value=0x1000.
- Ids 0 and 1 pending; channel 1 writes id1=0x22, then channel 0 writes id0=0x11 → commit order: id0 (0x11), then id1 (0x22), on consecutive cycles.
- Branch at id 3 written back with wb_mispredict=1, target=0x200 → commits with commit_rd=0; one cycle later flush=1, flush_pc=0x200; then empty=1 and issue_rob_id=0.
- Both channels target id 2 in one cycle (0xAA on ch0, 0xBB on ch1) → the stored value is 0xAA.
- Drive 20 issue/commit cycles so pointers wrap → commit_rob_id sequence is 0..15 then 0..3 with no loss; with ROB_WB_BYPASS_EN, get_id1 equal to a same-cycle wb id returns ready with that value combinationally.
